// File: rtl/ovl_never_arbiter_if.sv
// Requester-side handshake bundle for ovl_never_arbiter.
// The requesters drive valid/expr. The arbiter drives the one-hot ready grant.
interface ovl_never_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_expr;
    logic [NUM_REQ-1:0] req_ready;

    modport master (
        output req_valid,
        output req_expr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_expr,
        output req_ready
    );
endinterface

// File: rtl/ovl_never_arbiter.sv
// ovl_never_arbiter
//
// Shares one "never"-style assertion checker among NUM_REQ requesters.
// A round-robin arbiter picks one sample per cycle and forwards it, registered,
// to the checker's test_expr. The checker is held in reset for HOLDOFF+1 edges
// after system reset releases. The block also keeps per-source sticky fire
// flags, a saturating fire count and a one-cycle fire pulse tagged with its
// source.
//
// Optional feature macro: OVL_NEVER_ARB_XCHECK_EN
//   defined   : X/Z samples fire and are forwarded unchanged (4-state check)
//   undefined : X/Z samples neither fire nor propagate; they forward as 0
//
// state | meaning
// ------+--------------------------------------------------------------
// HOLD  | checker held in reset, no grants, hold-off counter running
// RUN   | checker released, round-robin arbitration active (left by reset only)
module ovl_never_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 8,
    parameter  int HOLDOFF = 2,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    ovl_never_arbiter_if.slave req,
    input  logic               clear,
    output logic               chk_reset,
    output logic               chk_expr,
    output logic [SRC_W-1:0]   chk_src,
    output logic               fire,
    output logic [SRC_W-1:0]   fire_src,
    output logic [NUM_REQ-1:0] fire_sticky,
    output logic [CNT_W-1:0]   fire_count
);

    localparam int HC_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [HC_W-1:0]    hold_cnt;
    logic [HC_W-1:0]    hold_cnt_nxt;

    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   ptr_nxt;
    logic [SRC_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               grant_found;
    logic               xfer;
    logic               sel_expr;
    logic               sel_hit;
    logic               fwd_val;
    logic               fire_hit;

    // FSM state and hold-off counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= HOLD;
            hold_cnt <= HC_W'(HOLDOFF);
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // FSM next state, hold-off countdown and checker reset decode
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        chk_reset    = 1'b0;
        case (state)
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end
            RUN: begin
                chk_reset = 1'b1;
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    // Round-robin search: first valid requester at or after the pointer, wrapping
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    // Grant decode; ready is only ever offered while running
    always_comb begin
        grant_oh            = '0;
        grant_oh[grant_idx] = 1'b1;
        xfer                = grant_found && (state == RUN);
        req.req_ready       = xfer ? grant_oh : '0;
        ptr_nxt             = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Sample classification for the winning requester
`ifdef OVL_NEVER_ARB_XCHECK_EN
    // Anything other than a clean 0 violates "never"; X/Z passes through untouched.
    always_comb begin
        sel_expr = req.req_expr[grant_idx];
        sel_hit  = (sel_expr !== 1'b0);
        fwd_val  = sel_expr;
        fire_hit = xfer && sel_hit;
    end
`else
    // Only a clean 1 counts; an unknown sample takes the else path and forwards 0.
    always_comb begin
        sel_expr = req.req_expr[grant_idx];
        sel_hit  = 1'b0;
        if (sel_expr == 1'b1) begin
            sel_hit = 1'b1;
        end
        fwd_val  = sel_hit;
        fire_hit = xfer && sel_hit;
    end
`endif

    // Priority pointer advances past the winner only on a transfer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= ptr_nxt;
        end
    end

    // Forwarding register: idle cycles present FALSE, source index holds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chk_expr <= 1'b0;
            chk_src  <= '0;
        end else if (xfer) begin
            chk_expr <= fwd_val;
            chk_src  <= grant_idx;
        end else begin
            chk_expr <= 1'b0;
        end
    end

    // Fire pulse and its source tag, aligned with the forwarded sample
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire     <= 1'b0;
            fire_src <= '0;
        end else begin
            fire <= fire_hit;
            if (fire_hit) begin
                fire_src <= grant_idx;
            end
        end
    end

    // Sticky flags and saturating count; a simultaneous fire survives a clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_sticky <= '0;
            fire_count  <= '0;
        end else if (clear) begin
            fire_sticky <= fire_hit ? grant_oh : '0;
            fire_count  <= fire_hit ? CNT_W'(1) : '0;
        end else if (fire_hit) begin
            fire_sticky <= fire_sticky | grant_oh;
            if (fire_count != {CNT_W{1'b1}}) begin
                fire_count <= fire_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/ovl_never_arbiter.md
# ovl_never_arbiter

Shares one `ovl_never`-style assertion checker among NUM_REQ requesters that each present a `test_expr` sample over a valid/ready handshake. A round-robin arbiter selects one sample per cycle and forwards it to the checker's `test_expr`. The block holds the checker in reset for a hold-off window after system reset. It also keeps per-source sticky fire flags, a saturating fire count and a fire pulse tagged with its source, for use by the bench.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..16.
- CNT_W, 8: width of the fire counter.
- HOLDOFF, 2: extra cycles the checker is held in reset after system reset releases.
- SRC_W, $clog2(NUM_REQ): derived; do not override.

- clock  in  1  single clock; all flops on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a sample.
- req_expr  in  NUM_REQ  sample value of requester i; may be X.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- clear  in  1  synchronous clear of fire_sticky and fire_count.
- chk_reset  out  1  active-low reset to the shared checker.
- chk_expr  out  1  forwarded sample, connected to the checker's `test_expr`.
- chk_src  out  SRC_W  index of the source of chk_expr.
- fire  out  1  one-cycle pulse: the forwarded sample violates "never".
- fire_src  out  SRC_W  source index that accompanies fire.
- fire_sticky  out  NUM_REQ  per-source latched fire flags.
- fire_count  out  CNT_W  saturating count of fires.

## Operation
- FSM with two states.
  - HOLD: entered on reset. req_ready = 0 and chk_reset = 0. The hold counter loads HOLDOFF and decrements on each edge. When the counter is 0 at an edge, the FSM moves to RUN.
  - RUN: chk_reset = 1 and arbitration is active. RUN is left only by reset.
- Arbitration:
  - req_ready is combinational from state, the priority pointer and req_valid.
  - The grant goes to the first valid requester at or after the pointer, wrapping from NUM_REQ-1 to 0.
  - No valid requester gives req_ready = 0.
  - On a transfer, the pointer becomes grant+1 modulo NUM_REQ. With no transfer, the pointer holds.
  - The pointer resets to 0.
- Forwarding, registered:
  - On a transfer, chk_expr <= req_expr[g] and chk_src <= g.
  - With no transfer, chk_expr <= 0 (FALSE) and chk_src holds.
- Fire detection (see Configuration):
  - A transferred sample equal to 1 fires.
  - At the same edge as the forward: fire <= 1, fire_src <= g, fire_sticky[g] <= 1, fire_count <= fire_count+1, saturating at 2^CNT_W-1.
  - fire is 0 in every other cycle.
- clear:
  - clear zeroes fire_sticky and fire_count.
  - If clear and a fire happen at the same edge, the fire wins for that source: fire_sticky = one-hot g and fire_count = 1.
- Reset mid-operation clears everything immediately and returns the FSM to HOLD. Any in-flight sample is discarded.

## Timing
- Reset values:
  - req_ready = 0, chk_reset = 0, chk_expr = 0, chk_src = 0.
  - fire = 0, fire_src = 0, fire_sticky = 0, fire_count = 0.
- HOLD covers the first HOLDOFF+1 rising edges after reset releases. req_ready can first be 1 in the following cycle.
- chk_reset rises at the same edge that enters RUN.
- Latency from a transfer at edge T: chk_expr, chk_src, fire, fire_src, fire_sticky and fire_count are all valid after edge T+1. The latency is 1.
- Throughput is one transfer per cycle. Requesters that stay valid are each served within NUM_REQ cycles.
- req_ready for a requester may drop without a transfer if another requester wins. Requesters must hold req_valid and req_expr until their transfer.

## Configuration
- OVL_NEVER_ARB_XCHECK_EN
  - Defined: a transferred sample that is X or Z also fires, matching checker behaviour on X. chk_expr forwards the X unchanged.
  - Undefined: X or Z samples do not fire and are forwarded as 0. The fire logic uses only 2-state comparison.

## Test plan
- Reset held low, req_valid = 4'b1111, req_expr = 4'b1111:
  - req_ready = 0, chk_reset = 0 and fire = 0 throughout reset.
  - After release, req_ready stays 0 for 3 edges (HOLDOFF = 2), then req_ready = 4'b0001.
- RUN with all four valid and req_expr = 0:
  - Grants go 0, 1, 2, 3, 0 on successive cycles.
  - chk_src follows one cycle later; fire never asserts and fire_count = 0.
- Requester 2 transfers req_expr = 1:
  - One cycle later: chk_expr = 1, fire = 1 for one cycle, fire_src = 2, fire_sticky = 4'b0100, fire_count = 1.
- Requester 1 transfers 1'bx:
  - With XCHECK_EN defined: fire = 1, fire_src = 1, fire_sticky[1] = 1.
  - With XCHECK_EN undefined: fire = 0 and chk_expr = 0.
- CNT_W = 2, five fires on requester 0:
  - fire_count reads 1, 2, 3, 3, 3.
  - clear asserted at the same edge as a sixth fire from requester 3 gives fire_count = 1 and fire_sticky = 4'b1000.
- Reset asserted during RUN with a transfer in flight:
  - All outputs return to 0 immediately, with no fire pulse.
  - HOLD repeats for 3 edges, then arbitration restarts from requester 0.
